// File: rtl/raccoon_responder.sv
// raccoon_responder: ring node that claims requests in its address window, performs one memory access and inserts the response.
module raccoon_responder #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [78:0] RaccIn,
  output logic [78:0] RaccOut,
  output logic        MEM_CS,
  output logic        MEM_WR,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_MASK,
  output logic [31:0] MEM_DOUT,
  input  logic [31:0] MEM_DIN,
  input  logic        MEM_ACK
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  localparam logic [7:0] LAST = TIMEOUT - 8'd1;
  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [4:0]  tag;
  logic [31:0] data;
  logic        err;
  logic        claim, insert;
  logic [78:0] rsp;
  always_comb begin
    claim  = RaccIn[78] && !RaccIn[77] && ((RaccIn[63:32] ^ BASE_ADDR) & ADDR_MASK) == 32'd0 && state == IDLE;
    insert = state == RESP && !RaccIn[78];
    rsp    = {1'b1, 1'b1, MEM_WR, MEM_MASK, 2'b00, err, tag, MEM_ADDR, data};
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      tag      <= '0;
      data     <= '0;
      err      <= 1'b0;
      RaccOut  <= '0;
      MEM_CS   <= 1'b0;
      MEM_WR   <= 1'b0;
      MEM_ADDR <= '0;
      MEM_MASK <= '0;
      MEM_DOUT <= '0;
    end else begin
      // a claimed request leaves an empty slot; forwarded traffic beats insertion
      RaccOut <= claim ? '0 : insert ? rsp : RaccIn;
      if (claim) begin
        state    <= ACCESS;
        cnt      <= '0;
        err      <= 1'b0;
        MEM_CS   <= 1'b1;
        MEM_WR   <= RaccIn[76];
        MEM_MASK <= RaccIn[75:72];
        tag      <= RaccIn[68:64];
        MEM_ADDR <= RaccIn[63:32];
        MEM_DOUT <= RaccIn[31:0];
      end else if (state == ACCESS) begin
        if (MEM_ACK) begin
          state  <= RESP;
          MEM_CS <= 1'b0;
          data   <= MEM_WR ? MEM_DOUT : MEM_DIN;
        end else if (cnt == LAST) begin
          state  <= RESP;
          MEM_CS <= 1'b0;
          data   <= 32'hDEAD_BEEF;
          err    <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else if (insert) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: doc/raccoon_responder.md
RACCOON_RESPONDER -- requirements
Module: raccoon_responder

Interface
REQ-001 Parameter BASE_ADDR, 32'hFFFF_0000, address value claimed by this node.
REQ-002 Parameter ADDR_MASK, 32'hFFFF_0000, address bits compared against BASE_ADDR.
REQ-003 Parameter TIMEOUT, 8'd255, maximum cycles to wait for MEM_ACK.
REQ-004 CLK  in  1  single clock; all logic rising-edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 RaccIn  in  79  ring packet from upstream node.
REQ-007 RaccOut  out  79  ring packet to downstream node, registered.
REQ-008 MEM_CS  out  1  local access strobe, held until MEM_ACK or timeout.
REQ-009 MEM_WR  out  1  1 = write.
REQ-010 MEM_ADDR  out  32  access address.
REQ-011 MEM_MASK  out  4  byte enables.
REQ-012 MEM_DOUT  out  32  write data.
REQ-013 MEM_DIN  in  32  read data, valid with MEM_ACK.
REQ-014 MEM_ACK  in  1  access complete; sampled only while MEM_CS=1.
REQ-015 Packet fields: [78] VLD, [77] RSP, [76] WR, [75:72] MASK, [71:69] reserved, [68:64] TAG (slice[68:67], reg[66:64]), [63:32] ADDR, [31:0] DATA.

Function
REQ-016 Claim condition: VLD=1, RSP=0, ((ADDR ^ BASE_ADDR) & ADDR_MASK)==0, FSM in IDLE.
REQ-017 Unclaimed packets (including all RSP=1 packets and claimable requests arriving while not IDLE) SHALL be forwarded unchanged to RaccOut one cycle later.
REQ-018 Claimed request SHALL be consumed; RaccOut slot of that cycle becomes available for insertion.
REQ-019 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on claim, capturing WR, MASK, TAG, ADDR, DATA.
REQ-020 ACCESS: MEM_CS=1 with captured fields driven on MEM_*; MEM_CS rises the cycle after claim.
REQ-021 ACCESS->RESP on MEM_ACK=1; read data captured from MEM_DIN; write responses echo captured DATA.
REQ-022 Wait counter counts ACCESS cycles; when it reaches TIMEOUT without MEM_ACK, MEM_CS drops, DATA=32'hDEAD_BEEF, reserved bit [69]=1 (error), ->RESP.
REQ-023 MEM_ACK and timeout in same cycle: MEM_ACK wins, no error.
REQ-024 RESP: response packet (VLD=1, RSP=1, WR/MASK/TAG/ADDR from request, DATA per REQ-021/022) inserted on RaccOut in the first cycle where incoming RaccIn VLD=0; forwarded traffic always has priority.
REQ-025 RESP->IDLE in the insertion cycle; a claimable request arriving in that same cycle SHALL be forwarded, not claimed.
REQ-026 Minimum latency claim-to-response on RaccOut: 3 cycles with MEM_ACK at first ACCESS cycle and empty ring.
REQ-027 At most one outstanding access; no internal queuing beyond the single capture register.
REQ-028 Reserved bits [71:70] of forwarded packets SHALL pass unmodified; responses drive them 0.

Reset
REQ-029 On RST: RaccOut=79'd0, MEM_CS=0, MEM_WR=0, MEM_ADDR/MASK/DOUT=0, FSM=IDLE, wait counter=0.
REQ-030 RST mid-ACCESS or mid-RESP SHALL abandon the transaction; no response emitted after RST deasserts.
REQ-031 RaccIn SHALL be ignored during RST cycles.

Verification
REQ-032 Read: RaccIn request ADDR=32'hFFFF_0010, TAG=5'h0B, MEM_ACK next cycle with MEM_DIN=32'h1234_5678 -> RaccOut response RSP=1, TAG=5'h0B, DATA=32'h1234_5678, 3 cycles after request.
REQ-033 Write: ADDR=32'hFFFF_0004, MASK=4'h3, DATA=32'hA5A5_0000 -> MEM_WR=1, MEM_MASK=4'h3, MEM_DOUT=32'hA5A5_0000; response echoes DATA.
REQ-034 Pass-through: ADDR=32'h0000_1000 request and any RSP=1 packet -> identical packet on RaccOut one cycle later, MEM_CS stays 0.
REQ-035 Busy/ring-full: second claimable request during ACCESS forwarded unchanged; continuous VLD=1 on RaccIn for 10 cycles delays response insertion until first empty slot.
REQ-036 Timeout: MEM_ACK held 0 -> MEM_CS drops after 255 cycles, response DATA=32'hDEAD_BEEF, bit[69]=1.
REQ-037 Reset mid-ACCESS: RST asserted during ACCESS -> MEM_CS=0 and RaccOut=0 next cycle; no later response.
